// File: rtl/dbus_sram_responder_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// dbus_sram_responder_pkg : data-bus request/response types and responder state
// Revision: 1.0
// -----------------------------------------------------------------------------
package dbus_sram_responder_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    DSR_IDLE = 2'd0,
    DSR_WAIT = 2'd1,
    DSR_RESP = 2'd2
  } dsr_state_t;

  localparam int c_cnt_w = 4;

endpackage
`default_nettype wire

// File: rtl/dbus_sram_responder_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// dbus_sram_if : data-bus request/response bundle between initiator and target
// Revision: 1.0
// -----------------------------------------------------------------------------
interface dbus_sram_if;
  import dbus_sram_responder_pkg::*;

  dbus_req_t  dreq;
  dbus_resp_t dresp;

  modport master (output dreq, input dresp);
  modport slave  (input dreq, output dresp);
endinterface
`default_nettype wire

// File: rtl/dbus_sram_responder_array.sv
`default_nettype none
// -----------------------------------------------------------------------------
// dbus_sram_array : MEM_WORDS x 32 single-port synchronous SRAM, byte writes
// Revision: 1.0
// -----------------------------------------------------------------------------
module dbus_sram_array #(
  parameter int    MEM_WORDS = 1024,
  parameter string INIT_FILE = ""
) (
  input  logic                         clk,
  input  logic                         en,
  input  logic [3:0]                   we,
  input  logic [$clog2(MEM_WORDS)-1:0] addr,
  input  logic [31:0]                  wdata,
  output logic [31:0]                  rdata
);

  logic [31:0] r_mem [MEM_WORDS];
  logic [31:0] r_rdata;

  // rdata only moves on an access, so it stays valid until the next accept.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) begin
          r_mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      r_rdata <= r_mem[addr];
    end
  end

  assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/dbus_sram_responder.sv
`default_nettype none
// -----------------------------------------------------------------------------
// dbus_sram_responder : data-bus target with programmable latency over a word SRAM
// Revision: 1.0
// -----------------------------------------------------------------------------
module dbus_sram_responder
  import dbus_sram_responder_pkg::*;
#(
  parameter int    MEM_WORDS = 1024,
  parameter int    LATENCY   = 2,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  dbus_sram_if.slave  dbus,
  input  logic        stall
);

  localparam int               AW         = $clog2(MEM_WORDS);
  localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(LATENCY - 1);

  dsr_state_t         r_state;
  dsr_state_t         w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_write;
  logic [31:0]        r_data;
  logic               w_accept;
  logic [31:0]        w_rdata;
  logic [31:0]        w_resp_data;
  dbus_resp_t         w_resp;
  logic               w_unused;

  assign w_unused    = ^{dbus.dreq.addr[31:AW+2], dbus.dreq.addr[1:0], dbus.dreq.size};
  // Gated by reset so nothing is offered while reset is held.
  assign w_accept    = (r_state == DSR_IDLE) & dbus.dreq.valid & ~stall & ~reset;
  assign w_resp_data = r_write ? 32'h0 : w_rdata;

  dbus_sram_array #(
    .MEM_WORDS (MEM_WORDS),
    .INIT_FILE (INIT_FILE)
  ) u_array (
    .clk   (clk),
    .en    (w_accept),
    .we    (dbus.dreq.strobe & {4{w_accept}}),
    .addr  (dbus.dreq.addr[AW+1:2]),
    .wdata (dbus.dreq.data),
    .rdata (w_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= DSR_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_write <= 1'b0;
      r_data  <= 32'h0;
    end else begin
      if (w_accept) begin
        r_cnt   <= c_cnt_init;
        r_write <= |dbus.dreq.strobe;
      end else if (r_state == DSR_WAIT) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (r_state == DSR_RESP) begin
        r_data <= w_resp_data;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      DSR_IDLE: if (w_accept) w_state_nxt = (LATENCY > 1) ? DSR_WAIT : DSR_RESP;
      DSR_WAIT: if (r_cnt == c_cnt_w'(1)) w_state_nxt = DSR_RESP;
      DSR_RESP: w_state_nxt = DSR_IDLE;
      default:  w_state_nxt = DSR_IDLE;
    endcase
  end

  always_comb begin
    w_resp.addr_ok = 1'b0;
    w_resp.data_ok = 1'b0;
    w_resp.data    = r_data;
    case (r_state)
      DSR_IDLE: w_resp.addr_ok = w_accept;
      DSR_RESP: begin
        w_resp.data_ok = 1'b1;
        w_resp.data    = w_resp_data;
      end
      default: ;
    endcase
  end

  assign dbus.dresp = w_resp;

endmodule
`default_nettype wire
